branch_predict_unit: RTL

- Parametrised successor to the combinational PC-select logic.
- Adds a direct-mapped branch history table (BHT) of 2-bit saturating counters, indexed by fetch PC, to predict conditional branches at IF.
- Resolves the branch outcome at EX from the comparator flags and drives PCSel and flush, including mispredict recovery.
- Sits between the fetch PC mux, the ID decoder and the EX branch comparator.

---
 rtl/branch_predict_unit.sv | 116 +++++++++++
 1 files changed

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - BHT-based branch predictor with EX-stage resolution and PC select
// Optional perf counters (br_count, mispred_count) enabled by defining BPU_PERF_CNT_EN.
module branch_predict_unit #(
  parameter int         XLEN     = 32,
  parameter int         IDX_BITS = 6,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  input  logic            is_jal_id,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_is_branch,
  input  logic            ex_is_jalr,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_pred_taken,
  input  logic            BrEq,
  input  logic            BrLt,
  input  logic            stall,
  output logic [1:0]      PCSel,
  output logic            flush
`ifdef BPU_PERF_CNT_EN
  ,
  output logic [31:0]     br_count,
  output logic [31:0]     mispred_count
`endif
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0]          r_bht [ENTRIES];
  logic [IDX_BITS-1:0] w_if_idx;
  logic [IDX_BITS-1:0] w_ex_idx;
  logic                w_taken;
  logic                w_legal;
  logic                w_resolved;
  logic                w_mispred;
  logic                w_update;

  assign w_if_idx = if_pc[IDX_BITS+1:2];
  assign w_ex_idx = ex_pc[IDX_BITS+1:2];

  // No bypass: an update landing this cycle is only visible next cycle.
  assign pred_taken = rst_n & r_bht[w_if_idx][1];

  always_comb begin
    w_legal = 1'b1;
    w_taken = 1'b0;
    case (ex_funct3)
      3'b000:         w_taken = BrEq;
      3'b001:         w_taken = !BrEq;
      3'b100, 3'b110: w_taken = BrLt;
      3'b101, 3'b111: w_taken = !BrLt;
      default:        w_legal = 1'b0;
    endcase
  end

  assign w_resolved = ex_valid && ex_is_branch && w_legal;
  assign w_mispred  = w_resolved && (w_taken != ex_pred_taken);
  assign w_update   = w_resolved && !stall;

  // EX redirects outrank a JAL sitting in ID.
  always_comb begin
    PCSel = 2'b00;
    flush = 1'b0;
    if (!rst_n) begin
      PCSel = 2'b00;
      flush = 1'b0;
    end else if (ex_valid && ex_is_jalr) begin
      PCSel = 2'b10;
      flush = 1'b1;
    end else if (w_mispred && w_taken) begin
      PCSel = 2'b10;
      flush = 1'b1;
    end else if (w_mispred) begin
      PCSel = 2'b11;
      flush = 1'b1;
    end else if (is_jal_id) begin
      PCSel = 2'b01;
      flush = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) r_bht[i] <= CNT_INIT;
    end else if (w_update) begin
      if (w_taken) begin
        if (r_bht[w_ex_idx] != 2'b11) r_bht[w_ex_idx] <= r_bht[w_ex_idx] + 2'b01;
      end else begin
        if (r_bht[w_ex_idx] != 2'b00) r_bht[w_ex_idx] <= r_bht[w_ex_idx] - 2'b01;
      end
    end
  end

`ifdef BPU_PERF_CNT_EN
  logic [31:0] r_br_count;
  logic [31:0] r_mispred_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_count      <= '0;
      r_mispred_count <= '0;
    end else if (w_update) begin
      r_br_count <= r_br_count + 32'd1;
      if (w_mispred) r_mispred_count <= r_mispred_count + 32'd1;
    end
  end

  assign br_count      = r_br_count;
  assign mispred_count = r_mispred_count;
`endif

endmodule
